// File: rtl/uart_pkg.sv
// Shared types and constants for the host-link UART (transmit now, receive later).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int WORD_BYTES = 4;
    localparam int DATA_BITS  = 8;

    // Width of a baud counter that runs 0..clks-1; never narrower than one bit.
    function automatic int cnt_width(input int clks);
        return (clks > 2) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_tx32_baud_gen.sv
// Bit-period timer: free-running 0..CLKS_PER_BIT-1 counter, one-cycle tick on the last count.
// Latency: tick on the CLKS_PER_BIT-th cycle after a clear.
// Backpressure: en low freezes the count (tick stays asserted if frozen on the last count).
// Ports: clk_i/rst_in clock and async active-low reset; clr synchronous clear (wins over en);
//        en count enable; tick high while the count equals CLKS_PER_BIT-1.
module baud_gen
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk_i,
    input  logic rst_in,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int            CW   = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx32.sv
// 32-bit word to four back-to-back 8N1 UART frames, least-significant byte first.
// Latency: start bit on tx_o the cycle after accept; word takes 40*CLKS_PER_BIT cycles.
// Backpressure: rdy_o low for the whole word; strobes while busy are dropped, not queued.
// Ports: clk_i, rst_in (async active low), data_i/stb_i/rdy_o word handshake, tx_o serial line.
// Optional UART_TX32_XONXOFF_EN: adds xon_i/xoff_i pulses that pause output between frames.
// CLKS_PER_BIT must be >= 2.
module uart_tx32
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk_i,
    input  logic        rst_in,
    input  logic [31:0] data_i,
    input  logic        stb_i,
    output logic        rdy_o,
`ifdef UART_TX32_XONXOFF_EN
    input  logic        xon_i,
    input  logic        xoff_i,
`endif
    output logic        tx_o
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic [1:0] LAST_BYTE = 2'(WORD_BYTES - 1);

    tx_state_e   state, state_nxt;
    logic [31:0] shreg, shreg_nxt;
    logic [2:0]  bit_idx, bit_nxt;
    logic [1:0]  byte_idx, byte_nxt;
    logic        tx_q, tx_nxt;
    logic        rdy_q, rdy_nxt;
    logic        baud_clr, baud_en, tick;
    logic        paused, paused_nxt;

`ifdef UART_TX32_XONXOFF_EN
    // xoff wins over a simultaneous xon.
    assign paused_nxt = xoff_i | (paused & ~xon_i);

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            paused <= 1'b0;
        end else begin
            paused <= paused_nxt;
        end
    end
`else
    assign paused     = 1'b0;
    assign paused_nxt = 1'b0;
`endif

    baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk_i (clk_i),
        .rst_in(rst_in),
        .clr   (baud_clr),
        .en    (baud_en),
        .tick  (tick)
    );

    always_comb begin
        state_nxt = state;
        shreg_nxt = shreg;
        bit_nxt   = bit_idx;
        byte_nxt  = byte_idx;
        baud_clr  = 1'b0;
        baud_en   = 1'b1;

        unique case (state)
            IDLE: begin
                // Keep the bit timer at 0 so the start bit gets a full period.
                baud_clr = 1'b1;
                if (stb_i && rdy_q) begin
                    shreg_nxt = data_i;
                    byte_nxt  = 2'd0;
                    bit_nxt   = 3'd0;
                    state_nxt = START;
                end
            end
            START: begin
                if (tick) begin
                    bit_nxt   = 3'd0;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_nxt = {1'b0, shreg[31:1]};
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = STOP;
                    end else begin
                        bit_nxt = bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    if (byte_idx == LAST_BYTE) begin
                        state_nxt = IDLE;
                    end else if (paused) begin
                        // Freeze on the last count: tick stays high, so the
                        // next byte starts the cycle after the pause clears.
                        baud_en = 1'b0;
                    end else begin
                        byte_nxt  = byte_idx + 2'd1;
                        state_nxt = START;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Line and ready are registered from next-state so the pad never glitches.
        unique case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shreg_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
        rdy_nxt = (state_nxt == IDLE) && !paused_nxt;
    end

    always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx_q     <= 1'b1;
            rdy_q    <= 1'b1;
        end else begin
            state    <= state_nxt;
            shreg    <= shreg_nxt;
            bit_idx  <= bit_nxt;
            byte_idx <= byte_nxt;
            tx_q     <= tx_nxt;
            rdy_q    <= rdy_nxt;
        end
    end

    assign tx_o  = tx_q;
    assign rdy_o = rdy_q;

endmodule

// File: tb/tb_uart_tx32.sv
// Bench for uart_tx32: directed and random words checked against a frame-level line model.
// Latency: n/a.
// Backpressure: n/a.
module tb_uart_tx32;

    localparam int N     = 4;
    localparam int FRAME = 10 * N;
    localparam int WORD  = 40 * N;

    logic        clk_i = 1'b0;
    logic        rst_in;
    logic [31:0] data_i;
    logic        stb_i;
    logic        rdy_o;
    logic        tx_o;
`ifdef UART_TX32_XONXOFF_EN
    logic        xon_i;
    logic        xoff_i;
`endif

    always #5 clk_i = ~clk_i;

    uart_tx32 #(
        .CLKS_PER_BIT(N)
    ) dut (
        .clk_i (clk_i),
        .rst_in(rst_in),
        .data_i(data_i),
        .stb_i (stb_i),
        .rdy_o (rdy_o),
`ifdef UART_TX32_XONXOFF_EN
        .xon_i (xon_i),
        .xoff_i(xoff_i),
`endif
        .tx_o  (tx_o)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: a word accepted at cycle c owns the line for cycles
    // c+1 .. c+40N (four frames of 10 bits each) and ready returns at c+40N+1.
    int         cyc       = 0;
    int         ready_cyc = 0;
    int         n_acc     = 0;
    int         n_frames  = 0;
    bit         loose     = 1'b0;
    logic [7:0] exp_q[$];
    int         exp_t[$];

    always @(posedge clk_i) begin
        if (rst_in && stb_i && (loose || cyc >= ready_cyc)) begin
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back(data_i[8*k +: 8]);
                exp_t.push_back(cyc + 1 + FRAME * k);
            end
            ready_cyc = cyc + WORD + 1;
            n_acc++;
        end
        cyc++;
    end

    // Line monitor: captures every cycle of a frame and compares the whole
    // 10-bit, N-cycles-per-bit waveform with the expected byte.
    bit               in_frame = 1'b0;
    bit               have_exp = 1'b0;
    int               fstart   = 0;
    logic [FRAME-1:0] smp;

    always @(negedge clk_i) begin
        if (!rst_in) begin
            exp_q.delete();
            exp_t.delete();
            in_frame  = 1'b0;
            ready_cyc = 0;
        end else begin
            if (!loose) chk("rdy", {31'd0, rdy_o}, {31'd0, cyc >= ready_cyc});
            if (!in_frame) begin
                if (tx_o === 1'b0) begin
                    in_frame = 1'b1;
                    fstart   = cyc;
                    smp      = '0;
                    have_exp = (exp_q.size() > 0);
                    if (!have_exp) chk("unexpected_start_tx", {31'd0, tx_o}, 32'd1);
                    else if (!loose) chk("start_cycle", cyc, exp_t[0]);
                end else if (!loose && exp_t.size() > 0 && cyc > exp_t[0]) begin
                    chk("missing_start_tx", {31'd0, tx_o}, 32'd0);
                    void'(exp_q.pop_front());
                    void'(exp_t.pop_front());
                end
            end
            if (in_frame) begin
                smp[cyc - fstart] = tx_o;
                if (cyc - fstart == FRAME - 1) begin
                    in_frame = 1'b0;
                    n_frames++;
                    if (have_exp) begin
                        logic [7:0] eb;
                        logic [7:0] got_b;
                        logic       ebit;
                        eb = exp_q.pop_front();
                        void'(exp_t.pop_front());
                        for (int b = 0; b < 10; b++) begin
                            ebit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : eb[b-1];
                            chk($sformatf("bit%0d_of_%02h", b, eb),
                                {28'd0, smp[b*N +: N]}, {28'd0, {N{ebit}}});
                        end
                        for (int b = 0; b < 8; b++) got_b[b] = smp[(b+1)*N + N/2];
                        chk("byte", {24'd0, got_b}, {24'd0, eb});
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_i);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        stb_i  = 1'b1;
        data_i = d;
        step(1);
        stb_i  = 1'b0;
        data_i = $urandom;
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 2000; i++) begin
            if (exp_q.size() == 0 && !in_frame) break;
            step(1);
        end
        if (i == 2000) chk("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int i;
        rst_in = 1'b0;
        stb_i  = 1'b0;
        data_i = '0;
`ifdef UART_TX32_XONXOFF_EN
        xon_i  = 1'b0;
        xoff_i = 1'b0;
`endif
        step(3);
        rst_in = 1'b1;
        chk("reset_tx", {31'd0, tx_o}, 32'd1);
        chk("reset_rdy", {31'd0, rdy_o}, 32'd1);
        step(10);
        chk("idle_tx", {31'd0, tx_o}, 32'd1);

        // Single word.
        send(32'h12345678);
        drain();
        step(3);

        // Strobe held high across two words; each sampled at its own accept.
        base   = n_acc;
        stb_i  = 1'b1;
        data_i = 32'hA5A5A5A5;
        step(1);
        data_i = 32'h0000FFFF;
        for (i = 0; i < 400; i++) begin
            if (n_acc >= base + 2) break;
            step(1);
        end
        stb_i = 1'b0;
        chk("held_stb_accepts", n_acc - base, 2);
        drain();
        step(2);

        // Strobe while busy is dropped.
        send(32'h00000001);
        step(49);
        send(32'hDEADBEEF);
        drain();
        step(2);

        // Bit 7 on the last data bit.
        send(32'h00000080);
        drain();
        step(2);

        // Asynchronous reset in the middle of a zero data bit.
        send(32'h00000000);
        step(6);
        chk("pre_reset_tx", {31'd0, tx_o}, 32'd0);
        @(posedge clk_i);
        #2 rst_in = 1'b0;
        #1;
        chk("async_reset_tx", {31'd0, tx_o}, 32'd1);
        chk("async_reset_rdy", {31'd0, rdy_o}, 32'd1);
        step(2);
        rst_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(10);
            chk("post_reset_idle_tx", {31'd0, tx_o}, 32'd1);
        end

        // Random strobes, including many while busy.
        for (int k = 0; k < 1500; k++) begin
            stb_i  = ($urandom_range(0, 99) < 8);
            data_i = $urandom;
            step(1);
        end
        stb_i = 1'b0;
        drain();
        chk("queue_empty", exp_q.size(), 0);

`ifdef UART_TX32_XONXOFF_EN
        // Flow control: timing of paused words is not modelled, content is.
        step(2);
        loose = 1'b1;
        base  = n_frames;
        send(32'h11223344);
        step(FRAME + 5);
        xoff_i = 1'b1;
        step(1);
        xoff_i = 1'b0;
        for (i = 0; i < 400; i++) begin
            if (n_frames >= base + 2) break;
            step(1);
        end
        chk("frames_before_pause", n_frames - base, 2);
        for (int k = 0; k < 10; k++) begin
            step(10);
            chk("paused_tx", {31'd0, tx_o}, 32'd1);
        end
        chk("paused_frames", n_frames - base, 2);
        xon_i = 1'b1;
        step(1);
        xon_i = 1'b0;
        drain();
        chk("frames_after_resume", n_frames - base, 4);
        xoff_i = 1'b1;
        step(1);
        xon_i  = 1'b1;
        step(1);
        xon_i  = 1'b0;
        xoff_i = 1'b0;
        step(2);
        chk("both_keeps_paused_rdy", {31'd0, rdy_o}, 32'd0);
        xon_i = 1'b1;
        step(1);
        xon_i = 1'b0;
        step(2);
        chk("resumed_rdy", {31'd0, rdy_o}, 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
